// File: rtl/gemm_pkg.sv
// Shared defaults and state encoding for the dense-layer sequencer and its loop counter.
package gemm_pkg;

   localparam int DEF_MAC_COUNT    = 32;
   localparam int DEF_ADDR_WIDTH   = 16;
   localparam int DEF_DIM_WIDTH    = 8;
   localparam int DEF_PIPE_LATENCY = 2;

   // One mask bit per MAC lane.
   localparam int LANE_MASK_W = DEF_MAC_COUNT;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DRAIN,
      ST_WB,
      ST_DONE
   } seq_state_t;

endpackage

// File: rtl/gemm_loop_counter.sv
// Nested k (input element) / t (output tile) counter with stall-gated advance.
module gemm_loop_counter
   import gemm_pkg::*;
#(
   parameter int DIM_WIDTH = DEF_DIM_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 k_en,
   input  logic                 t_en,
   input  logic [DIM_WIDTH-1:0] k_len,
   input  logic [DIM_WIDTH-1:0] t_len,
   output logic [DIM_WIDTH-1:0] k,
   output logic [DIM_WIDTH-1:0] t,
   output logic                 last_k,
   output logic                 last_t
);

   localparam logic [DIM_WIDTH-1:0] ONE = DIM_WIDTH'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         k <= '0;
         t <= '0;
      end else if (clear) begin
         k <= '0;
         t <= '0;
      end else if (t_en) begin
         k <= '0;
         t <= t + ONE;
      end else if (k_en) begin
         k <= last_k ? '0 : k + ONE;
      end
   end

   assign last_k = (k == k_len - ONE);
   assign last_t = (t == t_len - ONE);

endmodule

// File: rtl/gemm_layer_sequencer.sv
// Descriptor-driven command sequencer for one dense layer: walks MAC_COUNT-wide output
// tiles, issues fetch/accumulate commands and one writeback strobe per tile.
module gemm_layer_sequencer
   import gemm_pkg::*;
#(
   parameter int MAC_COUNT    = LANE_MASK_W,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int DIM_WIDTH    = DEF_DIM_WIDTH,
   parameter int PIPE_LATENCY = DEF_PIPE_LATENCY
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DIM_WIDTH-1:0]  cfg_in_len,
   input  logic [DIM_WIDTH-1:0]  cfg_out_len,
   input  logic [ADDR_WIDTH-1:0] cfg_weight_base,
   input  logic [ADDR_WIDTH-1:0] cfg_bias_base,
   input  logic [ADDR_WIDTH-1:0] cfg_act_in_base,
   input  logic [ADDR_WIDTH-1:0] cfg_act_out_base,
   input  logic                  stall,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  mac_issue,
   output logic                  mac_clear,
   output logic [ADDR_WIDTH-1:0] weight_addr,
   output logic [ADDR_WIDTH-1:0] act_rd_addr,
   output logic                  wb_en,
   output logic [ADDR_WIDTH-1:0] wb_act_addr,
   output logic [ADDR_WIDTH-1:0] wb_bias_addr,
   output logic [MAC_COUNT-1:0]  wb_lane_mask,
   output logic [DIM_WIDTH-1:0]  tile_index
);

   localparam int                    LANE_SHIFT = $clog2(MAC_COUNT);
   localparam int                    DRAIN_W    = $clog2(PIPE_LATENCY + 1);
   localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(PIPE_LATENCY - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(MAC_COUNT);
   localparam logic [DIM_WIDTH-1:0]  LANE_LOW   = DIM_WIDTH'(MAC_COUNT - 1);

   seq_state_t state, state_next;

   // Captured descriptor; only meaningful after an accepted start, so left unreset.
   logic [DIM_WIDTH-1:0]  in_len, out_len, tiles;
   logic [ADDR_WIDTH-1:0] act_in_base, wptr, out_ptr, bias_ptr;

   logic                  err_flag;
   logic [DRAIN_W-1:0]    drain_cnt;
   logic                  capture, k_en, t_en, zero_dim;
   logic [DIM_WIDTH-1:0]  k, t, remaining;
   logic                  last_k, last_t;

   logic                  busy_d, done_d, error_d, issue_d, clear_d, wb_en_d;
   logic [ADDR_WIDTH-1:0] weight_addr_d, act_rd_addr_d, wb_act_addr_d, wb_bias_addr_d;
   logic [MAC_COUNT-1:0]  wb_lane_mask_d;

   function automatic logic [MAC_COUNT-1:0] lane_mask(input logic [DIM_WIDTH-1:0] lanes_left);
      logic [MAC_COUNT-1:0] mask;
      for (int i = 0; i < MAC_COUNT; i++)
         mask[i] = (i < int'(lanes_left));
      return mask;
   endfunction

   assign zero_dim  = (cfg_in_len == '0) || (cfg_out_len == '0);
   assign remaining = out_len - (t << LANE_SHIFT);

   gemm_loop_counter #(
      .DIM_WIDTH (DIM_WIDTH)
   ) u_loop (
      .clk    (clk),
      .reset  (reset),
      .clear  (capture),
      .k_en   (k_en),
      .t_en   (t_en),
      .k_len  (in_len),
      .t_len  (tiles),
      .k      (k),
      .t      (t),
      .last_k (last_k),
      .last_t (last_t)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next     = state;
      capture        = 1'b0;
      k_en           = 1'b0;
      t_en           = 1'b0;
      busy_d         = busy;
      done_d         = 1'b0;
      error_d        = 1'b0;
      issue_d        = 1'b0;
      clear_d        = 1'b0;
      wb_en_d        = 1'b0;
      weight_addr_d  = weight_addr;
      act_rd_addr_d  = act_rd_addr;
      wb_act_addr_d  = wb_act_addr;
      wb_bias_addr_d = wb_bias_addr;
      wb_lane_mask_d = wb_lane_mask;
      case (state)
         ST_IDLE: begin
            if (start) begin
               capture    = 1'b1;
               busy_d     = 1'b1;
               state_next = zero_dim ? ST_DONE : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (!stall) begin
               issue_d       = 1'b1;
               clear_d       = (k == '0);
               weight_addr_d = wptr;
               act_rd_addr_d = act_in_base + ADDR_WIDTH'(k);
               k_en          = 1'b1;
               if (last_k)
                  state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt == DRAIN_LAST)
               state_next = ST_WB;
         end
         ST_WB: begin
            wb_en_d        = 1'b1;
            wb_act_addr_d  = out_ptr;
            wb_bias_addr_d = bias_ptr;
            wb_lane_mask_d = lane_mask(remaining);
            if (last_t) begin
               state_next = ST_DONE;
            end else begin
               t_en       = 1'b1;
               state_next = ST_ACCUM;
            end
         end
         ST_DONE: begin
            done_d     = 1'b1;
            error_d    = err_flag;
            busy_d     = 1'b0;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Tile count is a ceil built from shift plus remainder test, so N near 2^DIM_WIDTH cannot overflow.
   always_ff @(posedge clk) begin
      if (capture) begin
         in_len      <= cfg_in_len;
         out_len     <= cfg_out_len;
         tiles       <= (cfg_out_len >> LANE_SHIFT) + DIM_WIDTH'(|(cfg_out_len & LANE_LOW));
         act_in_base <= cfg_act_in_base;
         wptr        <= cfg_weight_base;
         out_ptr     <= cfg_act_out_base;
         bias_ptr    <= cfg_bias_base;
      end else begin
         if (k_en)
            wptr <= wptr + ADDR_STEP;
         if (t_en) begin
            out_ptr  <= out_ptr + ADDR_STEP;
            bias_ptr <= bias_ptr + ADDR_STEP;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_flag  <= 1'b0;
         drain_cnt <= '0;
      end else begin
         if (capture)
            err_flag <= zero_dim;
         drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
      end
   end

   // Output stage: every command the datapath sees comes straight from a flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         mac_issue    <= 1'b0;
         mac_clear    <= 1'b0;
         weight_addr  <= '0;
         act_rd_addr  <= '0;
         wb_en        <= 1'b0;
         wb_act_addr  <= '0;
         wb_bias_addr <= '0;
         wb_lane_mask <= '0;
         tile_index   <= '0;
      end else begin
         busy         <= busy_d;
         done         <= done_d;
         error        <= error_d;
         mac_issue    <= issue_d;
         mac_clear    <= clear_d;
         weight_addr  <= weight_addr_d;
         act_rd_addr  <= act_rd_addr_d;
         wb_en        <= wb_en_d;
         wb_act_addr  <= wb_act_addr_d;
         wb_bias_addr <= wb_bias_addr_d;
         wb_lane_mask <= wb_lane_mask_d;
         tile_index   <= t;
      end
   end

endmodule

// File: tb/tb_gemm_layer_sequencer.sv
// Directed bench for gemm_layer_sequencer: timing, addresses, masks, stall, errors, reset.
module tb_gemm_layer_sequencer;
   import gemm_pkg::*;

   localparam int AW = 16;
   localparam int DW = 8;
   localparam int MC = LANE_MASK_W;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          stall = 1'b0;
   logic [DW-1:0] cfg_in_len = '0;
   logic [DW-1:0] cfg_out_len = '0;
   logic [AW-1:0] cfg_weight_base = '0;
   logic [AW-1:0] cfg_bias_base = '0;
   logic [AW-1:0] cfg_act_in_base = '0;
   logic [AW-1:0] cfg_act_out_base = '0;
   logic          busy, done, error, mac_issue, mac_clear, wb_en;
   logic [AW-1:0] weight_addr, act_rd_addr, wb_act_addr, wb_bias_addr;
   logic [MC-1:0] wb_lane_mask;
   logic [DW-1:0] tile_index;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [AW-1:0] r_resume_act;

   always #5 clk = ~clk;

   gemm_layer_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .cfg_in_len       (cfg_in_len),
      .cfg_out_len      (cfg_out_len),
      .cfg_weight_base  (cfg_weight_base),
      .cfg_bias_base    (cfg_bias_base),
      .cfg_act_in_base  (cfg_act_in_base),
      .cfg_act_out_base (cfg_act_out_base),
      .stall            (stall),
      .busy             (busy),
      .done             (done),
      .error            (error),
      .mac_issue        (mac_issue),
      .mac_clear        (mac_clear),
      .weight_addr      (weight_addr),
      .act_rd_addr      (act_rd_addr),
      .wb_en            (wb_en),
      .wb_act_addr      (wb_act_addr),
      .wb_bias_addr     (wb_bias_addr),
      .wb_lane_mask     (wb_lane_mask),
      .tile_index       (tile_index)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Cycle 0 is the clock edge that samples start; values are read on the following falling edge.
   task automatic run_layer(input string name, input int k_len, input int n_len,
                            input logic [AW-1:0] wbase, input logic [AW-1:0] bbase,
                            input logic [AW-1:0] ibase, input logic [AW-1:0] obase,
                            input int stall_c, input int stall_n, input int disturb_c,
                            input int exp_issues, input int exp_done, input logic exp_err,
                            input int exp_wb_n, input int exp_wb_first, input int exp_wb_last,
                            input logic [MC-1:0] exp_last_mask, input logic [AW-1:0] exp_last_w);
      logic [AW-1:0] exp_w, last_w;
      logic [MC-1:0] last_mask;
      logic          busy0, busy_at_done, err_seen;
      int            exp_k, issues, seq_bad, wb_bad, wb_n, wb_first, wb_last;
      int            done_c, done_n, stall_issues;
      exp_w = wbase; last_w = '0; last_mask = '0;
      busy0 = 1'b0; busy_at_done = 1'b1; err_seen = 1'b0;
      exp_k = 0; issues = 0; seq_bad = 0; wb_bad = 0; wb_n = 0;
      wb_first = -1; wb_last = -1; done_c = -1; done_n = 0; stall_issues = 0;
      r_resume_act = '0;

      @(negedge clk);
      cfg_in_len = DW'(k_len); cfg_out_len = DW'(n_len);
      cfg_weight_base = wbase; cfg_bias_base = bbase;
      cfg_act_in_base = ibase; cfg_act_out_base = obase;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;

      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (c == 0) busy0 = busy;
         if (mac_issue) begin
            issues++;
            if (weight_addr !== exp_w) seq_bad++;
            if (act_rd_addr !== ibase + AW'(exp_k)) seq_bad++;
            if (mac_clear !== (exp_k == 0)) seq_bad++;
            last_w = weight_addr;
            exp_w  = exp_w + AW'(MC);
            exp_k  = (exp_k + 1 == k_len) ? 0 : exp_k + 1;
            if (stall_n > 0 && c >= stall_c && c < stall_c + stall_n) stall_issues++;
         end
         if (stall_n > 0 && c == stall_c + stall_n) r_resume_act = act_rd_addr;
         if (wb_en) begin
            if (wb_first < 0) wb_first = c;
            wb_last = c;
            if (wb_act_addr !== obase + AW'(wb_n * MC)) wb_bad++;
            if (wb_bias_addr !== bbase + AW'(wb_n * MC)) wb_bad++;
            if (wb_n < exp_wb_n - 1 && wb_lane_mask !== '1) wb_bad++;
            last_mask = wb_lane_mask;
            wb_n++;
         end
         if (done) begin
            if (done_c < 0) begin
               done_c = c;
               busy_at_done = busy;
               err_seen = error;
            end
            done_n++;
         end
         stall = (stall_n > 0) && (c + 1 >= stall_c) && (c + 1 < stall_c + stall_n);
         if (c == disturb_c) begin
            start = 1'b1;
            cfg_in_len = 8'd3; cfg_out_len = 8'd1;
            cfg_weight_base = 16'h5555; cfg_bias_base = 16'h6666;
            cfg_act_in_base = 16'h7777; cfg_act_out_base = 16'h8888;
         end else begin
            start = 1'b0;
         end
         if (done_c >= 0 && c >= done_c + 2) break;
      end
      stall = 1'b0;
      start = 1'b0;

      check_eq({name, "_busy0"}, busy0, 1'b1);
      check_eq({name, "_issues"}, issues, exp_issues);
      check_eq({name, "_seq"}, seq_bad, 0);
      check_eq({name, "_done_cycle"}, done_c, exp_done);
      check_eq({name, "_done_count"}, done_n, 1);
      check_eq({name, "_busy_at_done"}, busy_at_done, 1'b0);
      check_eq({name, "_error"}, err_seen, exp_err);
      check_eq({name, "_wb_count"}, wb_n, exp_wb_n);
      check_eq({name, "_wb_first"}, wb_first, exp_wb_first);
      check_eq({name, "_wb_last"}, wb_last, exp_wb_last);
      check_eq({name, "_wb_addr_mask"}, wb_bad, 0);
      check_eq({name, "_last_mask"}, last_mask, exp_last_mask);
      check_eq({name, "_last_waddr"}, last_w, exp_last_w);
      if (stall_n > 0) check_eq({name, "_stall_issues"}, stall_issues, 0);
   endtask

   initial begin
      int active;
      #2 reset = 1'b0;
      #1;
      check_eq("reset_ctrl", {busy, done, error, mac_issue, mac_clear, wb_en}, '0);
      check_eq("reset_addr", {weight_addr, act_rd_addr, wb_act_addr, wb_bias_addr}, '0);
      check_eq("reset_mask_tile", {wb_lane_mask, tile_index}, '0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      run_layer("k64n64", 64, 64, 16'h0000, 16'h0000, 16'h0000, 16'h0000, -1, 0, -1,
                128, 135, 1'b0, 2, 67, 134, 32'hFFFF_FFFF, 16'd4064);
      run_layer("k32n4", 32, 4, 16'h2000, 16'h0100, 16'h0040, 16'h0000, -1, 0, -1,
                32, 36, 1'b0, 1, 35, 35, 32'h0000_000F, 16'h23E0);
      run_layer("stall", 64, 64, 16'h0000, 16'h0000, 16'h0200, 16'h0000, 11, 3, -1,
                128, 138, 1'b0, 2, 70, 137, 32'hFFFF_FFFF, 16'd4064);
      check_eq("stall_resume_act", r_resume_act, 16'h020A);
      run_layer("k0", 0, 5, 16'h0100, 16'h0200, 16'h0300, 16'h0400, -1, 0, -1,
                0, 1, 1'b1, 0, -1, -1, 32'h0, 16'h0000);
      run_layer("n0", 3, 0, 16'h0100, 16'h0200, 16'h0300, 16'h0400, -1, 0, -1,
                0, 1, 1'b1, 0, -1, -1, 32'h0, 16'h0000);
      run_layer("disturb", 16, 40, 16'hFFF0, 16'h2000, 16'h0000, 16'h1000, -1, 0, 5,
                32, 39, 1'b0, 2, 19, 38, 32'h0000_00FF, 16'h03D0);
      run_layer("n255", 1, 255, 16'h0010, 16'h0300, 16'h0020, 16'h0400, -1, 0, -1,
                8, 33, 1'b0, 8, 4, 32, 32'h7FFF_FFFF, 16'h00F0);

      // Abort a layer at tile 1, k=20 with an asynchronous reset.
      @(negedge clk);
      cfg_in_len = 8'd64; cfg_out_len = 8'd64;
      cfg_weight_base = 16'h1000; cfg_bias_base = 16'h0900;
      cfg_act_in_base = 16'h0000; cfg_act_out_base = 16'h0800;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (89) @(negedge clk);
      check_eq("abort_pre_issue", mac_issue, 1'b1);
      check_eq("abort_pre_act", act_rd_addr, 16'd20);
      check_eq("abort_pre_tile", tile_index, 8'd1);
      reset = 1'b0;
      #1;
      check_eq("abort_ctrl", {busy, done, error, mac_issue, mac_clear, wb_en}, '0);
      check_eq("abort_addr", {weight_addr, act_rd_addr, wb_act_addr, wb_bias_addr}, '0);
      check_eq("abort_mask_tile", {wb_lane_mask, tile_index}, '0);
      active = 0;
      repeat (3) begin
         @(negedge clk);
         if (busy || mac_issue || wb_en || done) active++;
      end
      reset = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (busy || mac_issue || wb_en || done) active++;
      end
      check_eq("abort_quiet", active, 0);
      run_layer("after_abort", 32, 4, 16'h2000, 16'h0100, 16'h0040, 16'h0000, -1, 0, -1,
                32, 36, 1'b0, 1, 35, 35, 32'h0000_000F, 16'h23E0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
